seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. Each digit has its own anode line, and one shared hex-to-7-segment decoder drives the segments. The block holds the displayed hex value, presents one nibble at a time to the decoder, and drives the active-low anode of the matching digit. A blanking guard at the start of each digit slot prevents ghosting. New values are double-buffered so they only take effect at a frame boundary, which prevents tearing.

---
 rtl/seg7_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display. It presents one hex nibble at a time to an
// external shared decoder and drives the matching active-low anode. Each slot
// opens with a short blank phase to suppress ghosting. New values are
// double-buffered and only take effect on a frame boundary, so a frame never
// shows a mix of old and new digits.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   mask_in,
   output logic [3:0]              nibble_out,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    load_ack,
   output logic                    frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

   // Scan position: cnt is the cycle within the slot, dig the digit scanned.
   logic [CW-1:0]           cnt, cnt_nx;
   logic [DW-1:0]           dig, dig_nx;

   // Double buffer: active drives the display, shadow collects loads.
   logic [4*NUM_DIGITS-1:0] act_val, act_val_nx;
   logic [NUM_DIGITS-1:0]   act_msk, act_msk_nx;
   logic [4*NUM_DIGITS-1:0] sh_val;
   logic [NUM_DIGITS-1:0]   sh_msk;
   logic                    pending, pending_nx;

   // Decoded next-cycle outputs, registered below.
   logic                    slot_wrap, last_dig, boundary, xfer;
   logic                    in_blank;
   logic [3:0]              nib_nx;
   logic [NUM_DIGITS-1:0]   an_nx;
   logic                    fd_nx;

   // Advance the scan position and decide whether the shadow transfers.
   always_comb begin
      slot_wrap = (cnt == CNT_LAST);
      last_dig  = (dig == DIG_LAST);
      boundary  = slot_wrap && last_dig;
      xfer      = boundary && pending;

      cnt_nx = slot_wrap ? '0 : cnt + 1'b1;
      dig_nx = dig;
      if (slot_wrap)
         dig_nx = last_dig ? '0 : dig + 1'b1;

      act_val_nx = xfer ? sh_val : act_val;
      act_msk_nx = xfer ? sh_msk : act_msk;

      // A load on the boundary edge re-arms pending after the transfer,
      // so it is shown (and acknowledged) one frame later.
      pending_nx = pending;
      if (xfer)
         pending_nx = 1'b0;
      if (load)
         pending_nx = 1'b1;
   end

   // Outputs are computed for the cycle being entered so that every output
   // can be a plain register and still line up with the scan position.
   always_comb begin
      nib_nx   = 4'h0;
      in_blank = (int'(cnt_nx) < BLANK_CYCLES);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dig_nx == DW'(i))
            nib_nx = act_val_nx[4*i +: 4];
      end
      fd_nx = (dig_nx == DIG_LAST) && (cnt_nx == CNT_LAST);
   end

   // Per-digit anode enable: low only for the scanned, unmasked digit once
   // the blank phase of its slot is over.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_an
      assign an_nx[g] = !((dig_nx == DW'(g)) && !in_blank && !act_msk_nx[g]);
   end

   // Scan position and buffers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         dig     <= '0;
         act_val <= '0;
         act_msk <= '1;
         sh_val  <= '0;
         sh_msk  <= '0;
         pending <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         dig     <= dig_nx;
         act_val <= act_val_nx;
         act_msk <= act_msk_nx;
         pending <= pending_nx;
         if (load) begin
            sh_val <= value_in;
            sh_msk <= mask_in;
         end
      end
   end

   // Registered outputs; reset values keep the display dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nibble_out <= 4'h0;
         an_n       <= '1;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         nibble_out <= nib_nx;
         an_n       <= an_nx;
         load_ack   <= xfer;
         frame_done <= fd_nx;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
// An abstract model derives the expected outputs from the frame position
// (t mod 32) plus a double-buffered value; hand-computed literal points pin
// the model on each directed scenario.
module tb_seg7_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FR = ND * RD;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  mask_in;
   logic [3:0]  nibble_out;
   logic [3:0]  an_n;
   logic        load_ack;
   logic        frame_done;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
      .mask_in(mask_in), .nibble_out(nibble_out), .an_n(an_n),
      .load_ack(load_ack), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int sc     = 0;
   bit run    = 1'b0;

   // Model state: t counts cycles since reset release.
   int          t;
   logic [15:0] m_act, m_sh;
   logic [3:0]  m_msk, m_shm;
   bit          m_pend, m_ack;

   // Model: frame boundary transfer first (old shadow), then capture.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t = 0; m_act = '0; m_msk = 4'hF; m_sh = '0; m_shm = '0;
         m_pend = 0; m_ack = 0;
      end else begin
         m_ack = 0;
         if ((t % FR) == FR - 1 && m_pend) begin
            m_act = m_sh; m_msk = m_shm; m_pend = 0; m_ack = 1;
         end
         if (load) begin
            m_sh = value_in; m_shm = mask_in; m_pend = 1;
         end
         t++;
      end
   end

   typedef struct packed {
      logic [3:0] vm;   // [0]nibble [1]an [2]ack [3]frame_done
      logic [3:0] nib;
      logic [3:0] an;
      logic       ack;
      logic       fd;
   } lit_t;

   function automatic lit_t L(logic [3:0] vm, logic [3:0] nib, logic [3:0] an,
                              logic ack, logic fd);
      lit_t r;
      r.vm = vm; r.nib = nib; r.an = an; r.ack = ack; r.fd = fd;
      return r;
   endfunction

   function automatic lit_t lit_lookup(int key);
      case (key)
         1020: return L(4'h3, 4'h0, 4'hF, 0, 0);
         1030: return L(4'h8, 4'h0, 4'hF, 0, 0);
         1031: return L(4'h8, 4'h0, 4'hF, 0, 1);
         1063: return L(4'h8, 4'h0, 4'hF, 0, 1);
         2031: return L(4'h5, 4'h0, 4'hF, 0, 0);
         2032: return L(4'h7, 4'hC, 4'hF, 1, 0);
         2033: return L(4'h2, 4'h0, 4'hF, 0, 0);
         2034: return L(4'h2, 4'h0, 4'hE, 0, 0);
         2039: return L(4'h3, 4'hC, 4'hE, 0, 0);
         2040: return L(4'h3, 4'h7, 4'hF, 0, 0);
         2042: return L(4'h2, 4'h0, 4'hD, 0, 0);
         2050: return L(4'h3, 4'hA, 4'hB, 0, 0);
         2058: return L(4'h3, 4'h3, 4'h7, 0, 0);
         2063: return L(4'h8, 4'h0, 4'hF, 0, 1);
         3032: return L(4'h5, 4'h2, 4'hF, 1, 0);
         3033: return L(4'h4, 4'h0, 4'hF, 0, 0);
         4032: return L(4'h5, 4'h1, 4'hF, 1, 0);
         4063: return L(4'h1, 4'h1, 4'hF, 0, 0);
         4064: return L(4'h5, 4'h4, 4'hF, 1, 0);
         5034: return L(4'h3, 4'h8, 4'hE, 0, 0);
         5042: return L(4'h3, 4'h7, 4'hD, 0, 0);
         5050: return L(4'h3, 4'h6, 4'hF, 0, 0);
         5055: return L(4'h3, 4'h6, 4'hF, 0, 0);
         5058: return L(4'h3, 4'h5, 4'h7, 0, 0);
         6045: return L(4'h3, 4'h7, 4'hD, 0, 0);
         7010: return L(4'h3, 4'h0, 4'hF, 0, 0);
         7034: return L(4'h3, 4'h0, 4'hF, 0, 0);
         default: return L(4'h0, 4'h0, 4'h0, 0, 0);
      endcase
   endfunction

   task automatic chk(string nm, logic [3:0] got, logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s sc=%0d t=%0d: got %h expected %h", nm, sc, t, got, exp);
      end
   endtask

   // Single compare process: reset values while rst_n is low (including the
   // instant it falls), otherwise model plus any literal pinned to this cycle.
   always @(negedge clk or negedge rst_n) begin
      #1;
      if (run) begin
         if (!rst_n) begin
            chk("rst_an",  an_n,             4'hF);
            chk("rst_nib", nibble_out,       4'h0);
            chk("rst_ack", {3'b0, load_ack}, 4'h0);
            chk("rst_fd",  {3'b0, frame_done}, 4'h0);
         end else begin
            int pos, d, c;
            logic [3:0] e_an;
            lit_t lt;
            pos  = t % FR;
            d    = pos / RD;
            c    = pos % RD;
            e_an = 4'hF;
            if (c >= BC && !m_msk[d]) e_an[d] = 1'b0;
            chk("an",  an_n,               e_an);
            chk("nib", nibble_out,         m_act[4*d +: 4]);
            chk("ack", {3'b0, load_ack},   {3'b0, m_ack});
            chk("fd",  {3'b0, frame_done}, {3'b0, pos == FR - 1});
            lt = lit_lookup(sc * 1000 + t);
            if (lt.vm[0]) chk("lit_nib", nibble_out,         lt.nib);
            if (lt.vm[1]) chk("lit_an",  an_n,               lt.an);
            if (lt.vm[2]) chk("lit_ack", {3'b0, load_ack},   {3'b0, lt.ack});
            if (lt.vm[3]) chk("lit_fd",  {3'b0, frame_done}, {3'b0, lt.fd});
         end
      end
   end

   task automatic do_reset(int n);
      @(posedge clk); #2;
      rst_n = 1'b0; load = 1'b0;
      repeat (2) @(negedge clk);
      sc = n;
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_cyc(int c);
      while (t < c) @(negedge clk);
   endtask

   task automatic do_load(int c, logic [15:0] v, logic [3:0] m);
      wait_cyc(c);
      load = 1'b1; value_in = v; mask_in = m;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; load = 1'b0; value_in = '0; mask_in = '0;
      run = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      sc = 1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      wait_cyc(70);

      do_reset(2);
      do_load(10, 16'h3A7C, 4'b0000);
      wait_cyc(66);

      do_reset(3);
      do_load(5,  16'h1111, 4'b0000);
      do_load(20, 16'h2222, 4'b0000);
      wait_cyc(66);

      do_reset(4);
      do_load(5,  16'h1111, 4'b0000);
      do_load(31, 16'h4444, 4'b0000);
      wait_cyc(70);

      do_reset(5);
      do_load(3, 16'h5678, 4'b0100);
      wait_cyc(64);

      do_reset(6);
      do_load(2, 16'h5678, 4'b0000);
      wait_cyc(45);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      sc = 7;
      @(posedge clk); #2;
      rst_n = 1'b1;
      wait_cyc(40);

      @(negedge clk); #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
